rv_mem_banked: RTL and testbench

//  Parametrised successor of the rv32_core insn/data RAM. Memory split into NBANK contiguous banks.

---
 rtl/rv_mem_pkg.sv | 9 +
 rtl/rv_mem_bank.sv | 45 ++++
 rtl/rv_mem_banked.sv | 121 ++++++++++++
 tb/tb_rv_mem_banked.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared types and sizing helpers for the banked core RAM.
package rv_mem_pkg;
  localparam int MAX_NBANK = 4;
  typedef enum logic [1:0] {P_IDLE, P_WAIT, P_DONE} pstate_t;
  typedef logic [$clog2(MAX_NBANK)-1:0] bank_t;
  function automatic int nb_of(input int nk);
    return $clog2(nk) + 10;
  endfunction
endpackage

// File: rtl/rv_mem_bank.sv
// rv_mem_bank: one RAM bank, fetch on port A, D-bus or granted P-bus on port B.
module rv_mem_bank #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW:0]   a_hadr,
  output logic [31:0]   a_dr,
  input  logic [AW-1:0] d_adr,
  input  logic [31:0]   d_dw,
  input  logic [3:0]    d_we,
  input  logic          d_sel,
  input  logic [AW-1:0] p_adr,
  input  logic [31:0]   p_dw,
  input  logic          p_we,
  input  logic          p_sel,
  output logic [31:0]   b_dr
);
  // Halfword-split storage lets a fetch at an odd halfword take the next word's low half.
  logic [15:0] lo [2**AW];
  logic [15:0] hi [2**AW];
  logic [15:0] a_lo, a_hi;
  logic a_odd;
  logic [AW-1:0] wa, la, ba;
  logic [31:0] bw;
  logic [3:0] be;
  assign wa = a_hadr[AW:1];
  assign la = wa + AW'(a_hadr[0]);
  assign ba = p_sel ? p_adr : d_adr;
  assign bw = p_sel ? p_dw : d_dw;
  assign be = !en ? 4'h0 : p_sel ? {4{p_we}} : d_sel ? d_we : 4'h0;
  assign a_dr = a_odd ? {a_lo, a_hi} : {a_hi, a_lo};
  always_ff @(posedge clk) begin
    if (en) begin
      a_lo <= lo[la];
      a_hi <= hi[wa];
      a_odd <= a_hadr[0];
      b_dr <= {hi[ba], lo[ba]};
      if (be[0]) lo[ba][7:0] <= bw[7:0];
      if (be[1]) lo[ba][15:8] <= bw[15:8];
      if (be[2]) hi[ba][7:0] <= bw[23:16];
      if (be[3]) hi[ba][15:8] <= bw[31:24];
    end
  end
endmodule

// File: rtl/rv_mem_banked.sv
// rv_mem_banked: banked core RAM with fetch ports and D/P arbitration on port B.
module rv_mem_banked
  import rv_mem_pkg::*;
#(
  parameter int Nk = 32,
  parameter int NBANK = 2,
  parameter int P_MAXWAIT = 8,
  parameter int OREG = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy,
  input  logic [31:0] i_adr,
  input  logic        i_re,
  output logic [31:0] i_dr,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_dw,
  input  logic [3:0]  d_we,
  input  logic        d_re,
  output logic [31:0] d_dr,
  output logic        d_stall,
  input  logic [31:0] p_adr,
  input  logic [31:0] p_dw,
  input  logic        p_we,
  input  logic        p_re,
  output logic [31:0] p_dr,
  output logic        p_ack
);
  localparam int NB = nb_of(Nk);
  localparam int BW = $clog2(NBANK);
  localparam int AW = NB - 2 - BW;
  localparam int CW = $clog2(P_MAXWAIT + 1);
  function automatic bank_t bank_of(input logic [NB-1:0] a);
    return bank_t'(a >> (NB - BW));
  endfunction
  function automatic logic inr(input logic [31:0] a);
    return a[31:NB] == '0;
  endfunction
  pstate_t st, st_n;
  logic [CW-1:0] cnt;
  logic [NB-1:0] pa;
  logic [31:0] pw;
  logic pwe, p_oor, en, d_act, same, starve, wait_st, grant;
  logic d_rv, i_rv;
  bank_t db, pb, d_bq, i_bq;
  logic [31:0] a_dr [MAX_NBANK];
  logic [31:0] b_dr [MAX_NBANK];
  logic [31:0] i_raw, d_raw, p_raw;
  logic ack_raw, unused_bits;
  assign unused_bits = ^{i_adr[0], d_adr[1:0], pa[1:0]};
  assign en = rdy & !reset;
  assign db = bank_of(d_adr[NB-1:0]);
  assign pb = bank_of(pa);
  assign d_act = (|d_we | d_re) & inr(d_adr);
  assign same = d_act & (db == pb);
  assign starve = cnt == CW'(P_MAXWAIT);
  assign wait_st = st == P_WAIT;
  assign d_stall = wait_st & same & starve;
  assign grant = wait_st & en & (!same | starve);
  always_comb begin
    st_n = st;
    st_n = !en ? st :
           st == P_IDLE ? ((p_we | p_re) ? (inr(p_adr) ? P_WAIT : P_DONE) : P_IDLE) :
           st == P_WAIT ? (grant ? P_DONE : P_WAIT) : P_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= P_IDLE;
      cnt <= '0;
      pa <= '0;
      pw <= '0;
      pwe <= 1'b0;
      p_oor <= 1'b0;
      d_rv <= 1'b0;
      i_rv <= 1'b0;
      d_bq <= '0;
      i_bq <= '0;
    end else if (rdy) begin
      st <= st_n;
      if (st == P_IDLE) begin
        pa <= p_adr[NB-1:0];
        pw <= p_dw;
        pwe <= p_we;
        p_oor <= !inr(p_adr);
      end
      cnt <= grant ? '0 : (wait_st & same & !starve) ? cnt + CW'(1) : cnt;
      d_rv <= d_re & inr(d_adr) & !d_stall;
      d_bq <= db;
      i_rv <= i_re & inr(i_adr);
      i_bq <= bank_of(i_adr[NB-1:0]);
    end
  end
  for (genvar k = 0; k < MAX_NBANK; k++) begin : g_bank
    if (k < NBANK) begin : g_on
      rv_mem_bank #(.AW(AW)) u_bank (
        .clk(clk), .en(en),
        .a_hadr(i_adr[NB-BW-1:1]), .a_dr(a_dr[k]),
        .d_adr(d_adr[NB-BW-1:2]), .d_dw(d_dw), .d_we(d_we),
        .d_sel(d_act & !d_stall & (db == bank_t'(k))),
        .p_adr(pa[NB-BW-1:2]), .p_dw(pw), .p_we(pwe),
        .p_sel(grant & (pb == bank_t'(k))),
        .b_dr(b_dr[k])
      );
    end else begin : g_off
      assign a_dr[k] = '0;
      assign b_dr[k] = '0;
    end
  end
  assign i_raw = i_rv ? a_dr[i_bq] : '0;
  assign d_raw = d_rv ? b_dr[d_bq] : '0;
  assign ack_raw = st == P_DONE;
  assign p_raw = (ack_raw & !pwe & !p_oor) ? b_dr[pb] : '0;
  if (OREG != 0) begin : g_oreg
    always_ff @(posedge clk) begin
      if (reset) {i_dr, d_dr, p_dr, p_ack} <= '0;
      else if (rdy) {i_dr, d_dr, p_dr, p_ack} <= {i_raw, d_raw, p_raw, ack_raw};
    end
  end else begin : g_comb
    assign {i_dr, d_dr, p_dr, p_ack} = {i_raw, d_raw, p_raw, ack_raw};
  end
endmodule

// File: tb/tb_rv_mem_banked.sv
// tb_rv_mem_banked: directed checks of arbitration, starvation, ranges, rdy and OREG latency.
module tb_rv_mem_banked;
  logic clk = 0, reset = 1, rdy = 1, o = 0;
  logic [31:0] i_adr = 0, d_adr = 0, d_dw = 0, p_adr = 0, p_dw = 0;
  logic [3:0] d_we = 0;
  logic i_re = 0, d_re = 0, p_we = 0, p_re = 0;
  logic [31:0] i_dr0, d_dr0, p_dr0, i_dr1, d_dr1, p_dr1;
  logic d_stall0, p_ack0, d_stall1, p_ack1;
  int n = 0, nerr = 0;
  always #5 clk = ~clk;
  rv_mem_banked #(.OREG(0)) u0 (
    .clk(clk), .reset(reset), .rdy(rdy),
    .i_adr(i_adr), .i_re(i_re & !o), .i_dr(i_dr0),
    .d_adr(d_adr), .d_dw(d_dw), .d_we(o ? 4'h0 : d_we), .d_re(d_re & !o),
    .d_dr(d_dr0), .d_stall(d_stall0),
    .p_adr(p_adr), .p_dw(p_dw), .p_we(p_we & !o), .p_re(p_re & !o),
    .p_dr(p_dr0), .p_ack(p_ack0)
  );
  rv_mem_banked #(.OREG(1)) u1 (
    .clk(clk), .reset(reset), .rdy(rdy),
    .i_adr(i_adr), .i_re(i_re & o), .i_dr(i_dr1),
    .d_adr(d_adr), .d_dw(d_dw), .d_we(o ? d_we : 4'h0), .d_re(d_re & o),
    .d_dr(d_dr1), .d_stall(d_stall1),
    .p_adr(p_adr), .p_dw(p_dw), .p_we(p_we & o), .p_re(p_re & o),
    .p_dr(p_dr1), .p_ack(p_ack1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic dwr(input logic [31:0] a, input logic [31:0] v);
    d_adr = a; d_dw = v; d_we = 4'hF;
    tick;
    d_we = 0;
  endtask
  task automatic drd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    d_adr = a; d_re = 1;
    tick;
    d_re = 0;
    if (o) begin
      check({tag, "_lat"}, d_dr1, 0);
      tick;
    end
    check(tag, o ? d_dr1 : d_dr0, exp);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end
  initial begin
    tick; tick;
    check("rst_idr", i_dr0, 0); check("rst_ddr", d_dr0, 0); check("rst_pdr", p_dr0, 0);
    check("rst_ack", p_ack0, 0); check("rst_stall", d_stall0, 0);
    check("rst_ack1", p_ack1, 0); check("rst_ddr1", d_dr1, 0);
    reset = 0;
    dwr(32'h0, 32'hDEADBEEF); dwr(32'h200, 32'h11111111); dwr(32'h304, 32'h33333333);
    dwr(32'h4000, 32'h5A5A1234); dwr(32'h14, 32'h1234BEEF);
    // reset while a P write waits behind D on bank 0
    p_adr = 32'h200; p_dw = 32'h22222222; p_we = 1; d_adr = 0; d_re = 1;
    tick; tick;
    check("t1_wait_ack", p_ack0, 0);
    reset = 1; p_we = 0; d_re = 0;
    tick;
    check("t1_ack_r0", p_ack0, 0); check("t1_ddr", d_dr0, 0); check("t1_pdr", p_dr0, 0);
    check("t1_idr", i_dr0, 0); check("t1_stall", d_stall0, 0);
    tick;
    check("t1_ack_r1", p_ack0, 0);
    reset = 0;
    tick; check("t1_ack_a0", p_ack0, 0);
    tick; check("t1_ack_a1", p_ack0, 0);
    drd("t1_ram", 32'h200, 32'h11111111);
    // parallel D write bank 0 / P read bank 1
    p_adr = 32'h4000; p_re = 1;
    tick;
    d_adr = 32'h10; d_dw = 32'hCAFEF00D; d_we = 4'hF;
    #1;
    check("t2_stall", d_stall0, 0); check("t2_ack_early", p_ack0, 0);
    tick;
    check("t2_ack", p_ack0, 1); check("t2_pdr", p_dr0, 32'h5A5A1234);
    d_we = 0; p_re = 0;
    tick;
    check("t2_ack_drop", p_ack0, 0);
    drd("t2_dwr", 32'h10, 32'hCAFEF00D);
    // fetch: aligned, odd halfword, out of range
    i_adr = 32'h10; i_re = 1;
    tick; check("f_even", i_dr0, 32'hCAFEF00D);
    i_adr = 32'h12;
    tick; check("f_odd", i_dr0, 32'hBEEFCAFE);
    i_adr = 32'h10000;
    tick; check("f_oor", i_dr0, 0);
    i_re = 0;
    // starvation: D reads bank 0 every cycle
    p_adr = 32'h100; p_dw = 32'h12345678; p_we = 1; d_adr = 0; d_re = 1;
    tick;
    for (int i = 0; i < 9; i++) begin
      check("t3_stall", d_stall0, (i == 8) ? 32'd1 : 32'd0);
      check("t3_ack_wait", p_ack0, 0);
      if (i == 4) check("t3_ddr", d_dr0, 32'hDEADBEEF);
      if (i < 8) tick;
    end
    tick;
    check("t3_ack", p_ack0, 1); check("t3_stalled_ddr", d_dr0, 0); check("t3_stall_off", d_stall0, 0);
    p_we = 0; d_re = 0;
    tick;
    drd("t3_ram", 32'h100, 32'h12345678);
    // byte enables
    dwr(32'h20, 32'h11223344);
    d_adr = 32'h20; d_dw = 32'h00AA0000; d_we = 4'b0100;
    tick;
    d_we = 0; p_adr = 32'h20; p_re = 1;
    tick; tick;
    check("t4_ack", p_ack0, 1); check("t4_pdr", p_dr0, 32'h11AA3344);
    p_re = 0;
    tick;
    // out of range
    p_adr = 32'h10000; p_re = 1;
    tick;
    check("t5_ack", p_ack0, 1); check("t5_pdr", p_dr0, 0);
    p_re = 0;
    tick;
    check("t5_ack_drop", p_ack0, 0);
    drd("t5_ddr", 32'h10000, 0);
    // rdy low during P wait and a D write
    p_adr = 32'h300; p_dw = 32'h77777777; p_we = 1; d_adr = 0; d_re = 1;
    tick; tick;
    check("t6_ddr", d_dr0, 32'hDEADBEEF);
    rdy = 0; d_re = 0; d_adr = 32'h304; d_dw = 32'h99999999; d_we = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("t6_ack_hold", p_ack0, 0); check("t6_ddr_hold", d_dr0, 32'hDEADBEEF);
      check("t6_stall_hold", d_stall0, 0);
    end
    rdy = 1; d_we = 0; d_re = 1; d_adr = 0;
    #1;
    for (int i = 0; i < 8; i++) begin
      check("t6_stall", d_stall0, (i == 7) ? 32'd1 : 32'd0);
      if (i < 7) tick;
    end
    tick;
    check("t6_ack", p_ack0, 1);
    p_we = 0; d_re = 0;
    tick;
    drd("t6_nowr", 32'h304, 32'h33333333);
    drd("t6_pwr", 32'h300, 32'h77777777);
    // parallel access again with OREG=1
    o = 1;
    dwr(32'h4000, 32'h5A5A1234);
    p_adr = 32'h4000; p_re = 1;
    tick;
    d_adr = 32'h10; d_dw = 32'hCAFEF00D; d_we = 4'hF;
    #1;
    check("o_stall", d_stall1, 0); check("o_ack_early", p_ack1, 0);
    tick;
    check("o_ack_lat", p_ack1, 0);
    d_we = 0;
    tick;
    check("o_ack", p_ack1, 1); check("o_pdr", p_dr1, 32'h5A5A1234);
    p_re = 0;
    tick;
    check("o_ack_drop", p_ack1, 0);
    drd("o_dwr", 32'h10, 32'hCAFEF00D);
    $display("== %0d vectors applied, %0d miscompares ==", n, nerr);
    $finish;
  end
endmodule
